seq_detect_mm: RTL

Parametrised serial pattern detector FSM with both Mealy and Moore match outputs, a runtime-loadable pattern, selectable overlapping/non-overlapping detection and an optional saturating match counter. It generalises the team's fixed two-input Moore/Mealy control FSMs into a reusable block for lab datapaths: serial bit streams from switches or shift registers in, match strobes out to LEDs, seven-segment drivers or downstream control.

---
 rtl/seq_detect_mm.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_detect_mm.sv
// Serial pattern detector: runtime-loadable PAT_W-bit pattern, Mealy + Moore match strobes, optional saturating match counter (SEQDET_CNT_EN).
// Latency: match_mealy is combinational (0 cycles); match_moore, state_o and match_cnt update on the edge that consumes the bit (1 cycle).
// Backpressure: none; en=0 freezes the detector, load overrides en and restarts detection with the new pattern.
module seq_detect_mm #(
   parameter int          PAT_W    = 4,
   parameter int          CNT_W    = 8,
   parameter logic [15:0] PAT_INIT = 16'b1011
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       din,
   input  logic                       overlap,
   input  logic                       load,
   input  logic [PAT_W-1:0]           pat_in,
   output logic                       match_mealy,
   output logic                       match_moore,
   output logic [$clog2(PAT_W+1)-1:0] state_o,
   output logic [CNT_W-1:0]           match_cnt,
   output logic                       cnt_sat
);

   localparam int SW = $clog2(PAT_W+1);

   logic [PAT_W-1:0] pat_q;
   logic [SW-1:0]    state_q, state_d;
   logic [PAT_W-2:0] hist_q;
   logic             moore_q;

   // win[0] is the bit on din now, win[k] the bit consumed k bits earlier
   logic [PAT_W-1:0] win;
   logic             exp_bit;
   logic             last;
   logic             hit;
   logic             mealy;
   logic             ok;
   logic [SW-1:0]    fb;

   assign win  = {hist_q, din};
   assign last = (state_q == SW'(PAT_W-1));
   assign hit  = (din == exp_bit);

   // Pattern bit expected next for the current matched-prefix length
   always_comb begin
      exp_bit = 1'b0;
      for (int i = 0; i < PAT_W; i++) begin
         if (state_q == SW'(i)) exp_bit = pat_q[PAT_W-1-i];
      end
   end

   // Fallback: longest suffix of the window (length <= current state) equal to a pattern prefix.
   // Capping at state_q keeps bits from before the last restart out of the search; on a full
   // match the same search yields the longest proper border of the pattern.
   always_comb begin
      fb = '0;
      ok = 1'b0;
      for (int j = 1; j < PAT_W; j++) begin
         ok = 1'b1;
         for (int i = 0; i < j; i++) begin
            if (win[j-1-i] != pat_q[PAT_W-1-i]) ok = 1'b0;
         end
         if (ok && (SW'(j) <= state_q)) fb = SW'(j);
      end
   end

   // Next state: advance on expected bit, restart after a non-overlapping match, otherwise fall back
   always_comb begin
      state_d = fb;
      if (hit && !last) begin
         state_d = state_q + SW'(1);
      end else if (hit && last && !overlap) begin
         state_d = '0;
      end
   end

   assign mealy = en & ~load & last & (din == pat_q[0]);

   // Detector FSM: pattern, matched-prefix state, bit history and the Moore strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q   <= PAT_W'(PAT_INIT);
         state_q <= '0;
         hist_q  <= '0;
         moore_q <= 1'b0;
      end else begin
         moore_q <= mealy;
         if (load) begin
            pat_q   <= pat_in;
            state_q <= '0;
            hist_q  <= '0;
         end else if (en) begin
            state_q <= state_d;
            hist_q  <= win[PAT_W-2:0];
         end
      end
   end

`ifdef SEQDET_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating match counter, cleared by load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (mealy && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign match_cnt = cnt_q;
   assign cnt_sat   = &cnt_q;
`else
   assign match_cnt = '0;
   assign cnt_sat   = 1'b0;
`endif

   assign match_mealy = mealy;
   assign match_moore = moore_q;
   assign state_o     = state_q;

endmodule
